trace_buffer: RTL
=================

Name: trace_buffer

Overview:
- Sits directly downstream of trace_unit.
- Captures every trace_output record presented with trace_data_ready into a synchronous FIFO and drains it to a downstream consumer over a valid/ready handshake.
- Decouples the single-cycle trace_data_ready pulses from a consumer that may stall.
- Reports occupancy and counts records lost to overflow.

Parameters:
DEPTH, 16, number of stored records; power of two, >= 2
ALMOST_FULL_LEVEL, 12, occupancy at or above which almost_full asserts; 1..DEPTH
DROP_CNT_WIDTH, 16, width of saturating drop counter

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
trace_data_ready  input  1  push strobe from trace_unit; one record per high cycle
trace_data_i  input  trace_output  record to store
flush  input  1  synchronous empty request
clear_overflow  input  1  clears sticky overflow flag and drop counter
out_valid  output  1  head record present
out_ready  input  1  consumer accepts head when out_valid high
out_data  output  trace_output  head record
count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
empty  output  1  count == 0
full  output  1  count == DEPTH
almost_full  output  1  count >= ALMOST_FULL_LEVEL
overflow  output  1  sticky; set on any dropped record
drop_count  output  DROP_CNT_WIDTH  dropped records, saturating

Behaviour:
- Reset (rst high at clk edge) gives the following state. It takes priority over every other input, including mid-burst.
  - Read and write pointers = 0; count = 0.
  - out_valid = 0, empty = 1, full = 0, almost_full = 0.
  - overflow = 0, drop_count = 0.
  - out_data contents are don't-care.
- Defined terms:
  - pop = out_valid && out_ready.
  - push_req = trace_data_ready.
- Push accepted when push_req && (!full || pop). When full, a simultaneous pop frees the slot that same edge, so no record is dropped.
- Dropped record: push_req && full && !pop.
  - Record discarded; storage unchanged.
  - overflow <= 1.
  - drop_count increments, saturating at all-ones (no wrap).
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Count update:
  - accepted push without pop: count + 1;
  - pop without accepted push: count - 1;
  - both or neither: unchanged.
- Show-ahead read:
  - out_data = storage[read pointer] combinationally.
  - out_valid = !empty.
  - out_data is held stable while out_valid && !out_ready.
- Latency:
  - A record pushed at edge N is visible on out_valid/out_data after edge N (cycle N+1).
  - There is no same-cycle bypass; a push into an empty buffer does not raise out_valid in the push cycle.
- Ordering: strict FIFO. No record is duplicated or reordered.
- flush:
  - Pointers and count go to 0 at the edge.
  - Overrides any push or pop in the same cycle; that push is discarded and not counted as a drop.
  - overflow and drop_count unaffected.
- clear_overflow:
  - overflow <= 0; drop_count <= 0.
  - If a drop occurs in the same cycle, the drop wins: overflow = 1, drop_count = 1.
- empty, full and almost_full are derived from the registered count, i.e. they reflect the post-edge state.
- Storage carries no reset; only pointers and flags are reset.

Decomposition:
- trace_output is already defined in the shared package ryuki_datatypes; the buffer imports it and adds no new typedef.
- One sub-module, trace_buffer_mem:
  - DEPTH x $bits(trace_output) register array;
  - one write port (addr, data, we);
  - one asynchronous read port.
- trace_buffer holds the pointers, count, flags and drop counter.

Test Plan:
- DEPTH=4: push records A,B,C on three consecutive cycles with out_ready=0 -> count=3, out_data=A, empty=0, full=0. Then out_ready=1 for 3 cycles -> A,B,C in order, then empty=1, out_valid=0.
- DEPTH=4, ALMOST_FULL_LEVEL=3:
  - push 4 -> almost_full high at count 3, full=1 at count 4.
  - 5th push with out_ready=0 -> dropped; drop_count=1, overflow=1, head still the first record.
- Full buffer, push E with out_ready=1 in the same cycle -> head popped, E accepted, count stays 4, drop_count unchanged, E emerges last.
- Push into empty buffer at edge N -> out_valid=0 during push cycle, 1 from cycle N+1. Holding out_ready=0 for 5 cycles -> out_data stable.
- Fill 3 records, assert flush together with a push -> count=0, empty=1, drop_count unchanged, flushed push never appears.
- DROP_CNT_WIDTH=2: 5 drops -> drop_count saturates at 3. clear_overflow together with a drop -> overflow=1, drop_count=1. rst mid-drain -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/ryuki_datatypes.sv
// Shared datatypes of the ryuki trace path; trace_output is the record
// produced by trace_unit and carried unchanged through trace_buffer.
package ryuki_datatypes;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        rd_wen;
  } trace_output;

endpackage

// File: rtl/trace_buffer_pkg.sv
// Local constants and helpers for the trace buffer.
package trace_buffer_pkg;
  import ryuki_datatypes::*;

  localparam int TRACE_W = $bits(trace_output);

  // Keeps the almost-full threshold inside 1..depth so a bad override cannot
  // make almost_full unreachable or permanently asserted.
  function automatic int clamp_level(input int level, input int depth);
    int res;
    if (level < 1) begin
      res = 1;
    end else if (level > depth) begin
      res = depth;
    end else begin
      res = level;
    end
    return res;
  endfunction

endpackage

// File: rtl/trace_buffer_mem.sv
// Record storage for trace_buffer: one synchronous write port and one
// asynchronous read port. Contents are not reset.
module trace_buffer_mem
  import ryuki_datatypes::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  trace_output                wdata,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output trace_output                rdata
);

  trace_output mem_r [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/trace_buffer.sv
// Show-ahead FIFO behind trace_unit: absorbs single-cycle trace records,
// drains them over valid/ready, and counts records lost to overflow.
module trace_buffer
  import ryuki_datatypes::*;
  import trace_buffer_pkg::*;
#(
  parameter int DEPTH             = 16,
  parameter int ALMOST_FULL_LEVEL = 12,
  parameter int DROP_CNT_WIDTH    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      trace_data_ready,
  input  trace_output               trace_data_i,
  input  logic                      flush,
  input  logic                      clear_overflow,
  output logic                      out_valid,
  input  logic                      out_ready,
  output trace_output               out_data,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      empty,
  output logic                      full,
  output logic                      almost_full,
  output logic                      overflow,
  output logic [DROP_CNT_WIDTH-1:0] drop_count
);

  localparam int AW       = $clog2(DEPTH);
  localparam int CW       = AW + 1;
  localparam int AF_LEVEL = clamp_level(ALMOST_FULL_LEVEL, DEPTH);

  localparam logic [AW-1:0]             PTR_ONE  = AW'(1'b1);
  localparam logic [CW-1:0]             CNT_ONE  = CW'(1'b1);
  localparam logic [CW-1:0]             CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0]             CNT_AF   = CW'(AF_LEVEL);
  localparam logic [DROP_CNT_WIDTH-1:0] DROP_ONE = DROP_CNT_WIDTH'(1'b1);
  localparam logic [DROP_CNT_WIDTH-1:0] DROP_MAX = {DROP_CNT_WIDTH{1'b1}};

  logic [AW-1:0]             wr_ptr_r;
  logic [AW-1:0]             rd_ptr_r;
  logic [AW-1:0]             wr_ptr_nxt_s;
  logic [AW-1:0]             rd_ptr_nxt_s;
  logic [CW-1:0]             count_nxt_s;
  logic                      pop_s;
  logic                      push_ok_s;
  logic                      drop_s;
  logic                      overflow_nxt_s;
  logic [DROP_CNT_WIDTH-1:0] drop_count_nxt_s;

  trace_buffer_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push_ok_s),
    .waddr (wr_ptr_r),
    .wdata (trace_data_i),
    .raddr (rd_ptr_r),
    .rdata (out_data)
  );

  // Handshake decode, pointer/count next state and overflow bookkeeping
  always_comb begin
    pop_s            = out_valid && out_ready;
    push_ok_s        = 1'b0;
    drop_s           = 1'b0;
    wr_ptr_nxt_s     = wr_ptr_r;
    rd_ptr_nxt_s     = rd_ptr_r;
    count_nxt_s      = count;
    overflow_nxt_s   = overflow;
    drop_count_nxt_s = drop_count;

    // Flush discards the same-cycle push outright; it is neither stored nor a drop.
    if (flush) begin
      wr_ptr_nxt_s = '0;
      rd_ptr_nxt_s = '0;
      count_nxt_s  = '0;
    end else begin
      push_ok_s = trace_data_ready && (!full || pop_s);
      drop_s    = trace_data_ready && full && !pop_s;
      if (push_ok_s) begin
        wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_nxt_s = wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_nxt_s = rd_ptr_r;
      end
      case ({push_ok_s, pop_s})
        2'b10:   count_nxt_s = count + CNT_ONE;
        2'b01:   count_nxt_s = count - CNT_ONE;
        default: count_nxt_s = count;
      endcase
    end

    // A drop in the same cycle as clear_overflow restarts the count at one.
    if (drop_s) begin
      overflow_nxt_s = 1'b1;
      if (clear_overflow) begin
        drop_count_nxt_s = DROP_ONE;
      end else if (drop_count == DROP_MAX) begin
        drop_count_nxt_s = drop_count;
      end else begin
        drop_count_nxt_s = drop_count + DROP_ONE;
      end
    end else if (clear_overflow) begin
      overflow_nxt_s   = 1'b0;
      drop_count_nxt_s = '0;
    end else begin
      overflow_nxt_s   = overflow;
      drop_count_nxt_s = drop_count;
    end
  end

  // State and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      count       <= '0;
      out_valid   <= 1'b0;
      empty       <= 1'b1;
      full        <= 1'b0;
      almost_full <= 1'b0;
      overflow    <= 1'b0;
      drop_count  <= '0;
    end else begin
      wr_ptr_r    <= wr_ptr_nxt_s;
      rd_ptr_r    <= rd_ptr_nxt_s;
      count       <= count_nxt_s;
      out_valid   <= (count_nxt_s != '0);
      empty       <= (count_nxt_s == '0);
      full        <= (count_nxt_s == CNT_FULL);
      almost_full <= (count_nxt_s >= CNT_AF);
      overflow    <= overflow_nxt_s;
      drop_count  <= drop_count_nxt_s;
    end
  end

endmodule
